// File: rtl/led_player_pkg.sv
// Shared types and constants for the LED pattern player.
package led_player_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Duration field position inside a frame word.
    localparam int DUR_MSB = 31;
    localparam int DUR_LSB = 16;

    // Clocks per duration tick when the top is not overridden.
    localparam int unsigned TICK_DIV_DEFAULT = 50000;

endpackage

// File: rtl/led_pattern_fifo.sv
// Small synchronous show-ahead FIFO used as the frame prefetch buffer.
module led_pattern_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clear drops all entries at once.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage write port.
    // NOTE: the array has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // The fetch side reserves space before reading, so a push into a full buffer is a design error.
    always_ff @(posedge clk) begin
        if (reset_n && !clear) begin
            assert (!(push && full)) else $error("led_pattern_fifo: push while full");
        end
    end

endmodule

// File: rtl/led_pattern_player.sv
// Avalon-MM read master that prefetches frame words from the pattern RAM and plays them on the LEDs.
module led_pattern_player
    import led_player_pkg::*;
#(
    parameter int          ADDR_W     = 12,
    parameter int          DATA_W     = 32,
    parameter int          LED_W      = 10,
    parameter int unsigned TICK_DIV   = TICK_DIV_DEFAULT,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_words,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    output logic              m_clken,
    input  logic [DATA_W-1:0] m_readdata,
    output logic [LED_W-1:0]  leds,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] num_q;
    logic              loop_q;
    logic [ADDR_W-1:0] idx;
    logic              fetch_done;
    logic              inflight;
    logic [31:0]       frame_timer;

    logic              accept;
    logic              flush;
    logic              issue;
    logic              pop;
    logic              done_next;

    logic [DATA_W-1:0] fifo_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    logic [15:0]       dur_field;
    logic [31:0]       dur_ticks;
    logic [31:0]       frame_cycles;
    logic              unused_bits;

    assign m_write      = 1'b0;
    assign m_byteenable = 4'hF;
    assign m_clken      = 1'b1;

    assign busy         = (state == RUN);
    assign m_address    = base_q + idx;
    assign m_chipselect = issue;

    // A read is issued only when its word is guaranteed a free FIFO slot.
    assign issue = (state == RUN) && !fetch_done &&
                   ((fifo_count + CNT_W'(inflight)) < CNT_W'(FIFO_DEPTH));

    // A zero duration still shows the frame for one tick.
    assign dur_field    = fifo_data[DUR_MSB:DUR_LSB];
    assign dur_ticks    = (dur_field == '0) ? 32'd1 : {16'd0, dur_field};
    assign frame_cycles = dur_ticks * TICK_DIV - 32'd1;

    assign unused_bits  = ^{fifo_full, fifo_data[DUR_LSB-1:LED_W]};

    led_pattern_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (flush),
        .push      (inflight),
        .push_data (m_readdata),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Next-state and control strobes; start beats stop in IDLE, stop beats everything in RUN.
    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        flush      = 1'b0;
        pop        = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (num_words != '0) state_next = RUN;
                    else                 done_next  = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    flush      = 1'b1;
                    state_next = IDLE;
                end else begin
                    pop = (frame_timer == '0) && !fifo_empty;
                    if (fetch_done && fifo_empty && !inflight && (frame_timer == '0)) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Job parameters captured on an accepted start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            base_q <= '0;
            num_q  <= '0;
            loop_q <= 1'b0;
        end else if (accept) begin
            base_q <= base_addr;
            num_q  <= num_words;
            loop_q <= loop_en;
        end
    end

    // Fetch index, end-of-fetch flag and the single outstanding-read marker.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx        <= '0;
            fetch_done <= 1'b0;
            inflight   <= 1'b0;
        end else if (accept) begin
            idx        <= '0;
            fetch_done <= 1'b0;
            inflight   <= 1'b0;
        end else if (flush) begin
            inflight   <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                if (idx == num_q - 1'b1) begin
                    if (loop_q) idx        <= '0;
                    else        fetch_done <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    // Play side: frame timer, LED register and completion pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            leds        <= '0;
            frame_timer <= '0;
            done        <= 1'b0;
        end else begin
            done <= done_next;
            if (flush) begin
                frame_timer <= '0;
            end else if (pop) begin
                leds        <= fifo_data[LED_W-1:0];
                frame_timer <= frame_cycles;
            end else if (frame_timer != '0) begin
                frame_timer <= frame_timer - 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_player.sv
// Self-checking bench for led_pattern_player with a 1-cycle-latency RAM model and a frame-timeline reference.
module tb_led_pattern_player;

    localparam int TD    = 4;
    localparam int DEPTH = 4;
    localparam int RAM_N = 2560;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic [11:0] base_addr;
    logic [11:0] num_words;
    logic        loop_en;
    logic [11:0] m_address;
    logic        m_chipselect;
    logic        m_write;
    logic [3:0]  m_byteenable;
    logic        m_clken;
    logic [31:0] m_readdata;
    logic [9:0]  leds;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ram [RAM_N];

    // Reference job description and state carried between scenarios.
    logic [31:0] m_words [$];
    int          m_base;
    int          m_num;
    bit          m_loop;
    logic [9:0]  held_leds;
    int          last_done_edge;

    always #5 clk = ~clk;

    led_pattern_player #(.TICK_DIV(TD)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .stop         (stop),
        .base_addr    (base_addr),
        .num_words    (num_words),
        .loop_en      (loop_en),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write      (m_write),
        .m_byteenable (m_byteenable),
        .m_clken      (m_clken),
        .m_readdata   (m_readdata),
        .leds         (leds),
        .busy         (busy),
        .done         (done)
    );

    // On-chip RAM model: zero wait states, data valid the cycle after the address.
    always @(posedge clk) begin
        if (m_chipselect && (m_address < RAM_N)) m_readdata <= ram[m_address];
    end

    // Cycles a frame stays on the LEDs.
    function automatic int flen(input int i);
        logic [31:0] w;
        int d;
        w = m_words[i % m_num];
        d = int'(w[31:16]);
        if (d == 0) d = 1;
        return d * TD;
    endfunction

    // Number of frames that have been put on the LEDs by edge k (first at edge 3).
    function automatic int frames_started(input int k);
        int t;
        int n;
        t = 3;
        n = 0;
        while ((t <= k) && (m_loop || (n < m_num))) begin
            t += flen(n);
            n++;
        end
        return n;
    endfunction

    function automatic logic [9:0] exp_leds(input int k);
        int n;
        logic [31:0] w;
        n = frames_started(k);
        if (n == 0) return held_leds;
        w = m_words[(n - 1) % m_num];
        return w[9:0];
    endfunction

    function automatic int done_edge();
        int total;
        total = 0;
        for (int i = 0; i < m_num; i++) total += flen(i);
        return (m_num == 0) ? 0 : 3 + total;
    endfunction

    // Load the job into RAM, start it, and compare every cycle against the timeline model.
    // Inputs are sampled at edge k when driven in the half cycle before it.
    task automatic run_trace(input int n_cycles, input int stop_at, input int restart_at, input int reset_at);
        int          reads;
        int          de;
        bit          halted;
        logic [9:0]  frozen;
        logic [9:0]  e_leds;
        bit          e_busy;
        bit          e_done;
        bit          e_cs;
        logic [11:0] e_addr;
        reads  = 0;
        halted = 1'b0;
        frozen = '0;
        de     = done_edge();
        last_done_edge = -1;
        for (int i = 0; i < m_num; i++) ram[m_base + i] = m_words[i];
        @(negedge clk);
        base_addr = 12'(m_base);
        num_words = 12'(m_num);
        loop_en   = m_loop;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < n_cycles; k++) begin
            if (k == reset_at) begin
                halted = 1'b1;
                frozen = '0;
            end else if (k == stop_at && !halted) begin
                halted = 1'b1;
                frozen = exp_leds(k - 1);
            end
            if (halted) begin
                e_leds = frozen;
                e_busy = 1'b0;
                e_done = 1'b0;
                e_cs   = 1'b0;
            end else begin
                e_leds = exp_leds(k);
                e_busy = (m_num > 0) && (m_loop || (k < de));
                e_done = !m_loop && (k == de);
                e_cs   = e_busy && (m_loop || (reads < m_num)) &&
                         ((reads - frames_started(k)) < DEPTH);
            end
            e_addr = (m_num > 0) ? 12'(m_base + reads % m_num) : 12'(m_base);
            if (done === 1'b1) last_done_edge = k;

            checks++;
            if (leds !== e_leds) begin
                failures++;
                $display("FAIL leds edge=%0d got=%h exp=%h", k, leds, e_leds);
            end
            checks++;
            if (busy !== e_busy) begin
                failures++;
                $display("FAIL busy edge=%0d got=%b exp=%b", k, busy, e_busy);
            end
            checks++;
            if (done !== e_done) begin
                failures++;
                $display("FAIL done edge=%0d got=%b exp=%b", k, done, e_done);
            end
            checks++;
            if (m_chipselect !== e_cs) begin
                failures++;
                $display("FAIL chipselect edge=%0d got=%b exp=%b outstanding=%0d", k, m_chipselect, e_cs,
                         reads - frames_started(k));
            end
            if (e_cs) begin
                checks++;
                if (m_address !== e_addr) begin
                    failures++;
                    $display("FAIL address edge=%0d got=%h exp=%h", k, m_address, e_addr);
                end
                reads++;
            end
            checks++;
            if ({m_write, m_byteenable, m_clken} !== 6'b0_1111_1) begin
                failures++;
                $display("FAIL tieoffs edge=%0d got=%b exp=011111", k, {m_write, m_byteenable, m_clken});
            end

            start     = (k + 1 == restart_at);
            stop      = (k + 1 == stop_at);
            reset_n   = !(k + 1 == reset_at);
            if (k + 1 == restart_at) begin
                base_addr = 12'($urandom_range(RAM_N - 8));
                num_words = 12'($urandom_range(7, 1));
                loop_en   = $urandom_range(1);
            end
            @(negedge clk);
        end
        start   = 1'b0;
        stop    = 1'b0;
        reset_n = 1'b1;
        held_leds = halted ? frozen : exp_leds(n_cycles - 1);
    endtask

    function automatic logic [31:0] rand_word(input int max_dur);
        return {16'($urandom_range(max_dur)), 6'($urandom), 10'($urandom)};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({leds, busy, done, m_chipselect, m_address} !== 25'd0) begin
            failures++;
            $display("FAIL reset_state got leds=%h busy=%b done=%b cs=%b addr=%h exp all zero",
                     leds, busy, done, m_chipselect, m_address);
        end
        reset_n = 1'b1;
        held_leds = '0;
    endtask

    task automatic test_basic();
        m_words = '{32'h0001_0155, 32'h0002_02AA, 32'h0001_0003};
        m_base  = 'h010;
        m_num   = 3;
        m_loop  = 1'b0;
        run_trace(25, -1, -1, -1);
        checks++;
        if (last_done_edge != 19) begin
            failures++;
            $display("FAIL basic_done_edge got=%0d exp=19", last_done_edge);
        end
    endtask

    task automatic test_loop_stop();
        int s;
        m_words = '{{16'd1, 6'd0, 10'($urandom)}, {16'd1, 6'd0, 10'($urandom)}};
        m_base  = $urandom_range(RAM_N - 2);
        m_num   = 2;
        m_loop  = 1'b1;
        s = 30 + $urandom_range(7);
        run_trace(s + 8, s, -1, -1);
        checks++;
        if (last_done_edge != -1) begin
            failures++;
            $display("FAIL stop_no_done got done at edge %0d exp none", last_done_edge);
        end
    endtask

    task automatic test_zero_words();
        m_words = {};
        m_base  = $urandom_range(RAM_N - 1);
        m_num   = 0;
        m_loop  = 1'b0;
        run_trace(6, -1, -1, -1);
        checks++;
        if (last_done_edge != 0) begin
            failures++;
            $display("FAIL zero_done_edge got=%0d exp=0", last_done_edge);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            m_num   = $urandom_range(6, 1);
            m_words = {};
            for (int i = 0; i < m_num; i++) m_words.push_back(rand_word(3));
            m_base  = $urandom_range(RAM_N - m_num);
            m_loop  = 1'b0;
            run_trace(done_edge() + 4, -1, -1, -1);
        end
    endtask

    task automatic test_long_frames();
        m_words = '{{16'h4001, 6'd0, 10'($urandom)}, {16'hFFFF, 6'd0, 10'($urandom)}, rand_word(0),
                    rand_word(0), {16'hFFFF, 6'd0, 10'($urandom)}, rand_word(3), rand_word(3)};
        m_num   = 7;
        m_base  = $urandom_range(RAM_N - m_num);
        m_loop  = 1'b0;
        run_trace(206, 200, -1, -1);
    endtask

    task automatic test_reset_mid_run();
        int ra;
        for (int r = 0; r < 2; r++) begin
            m_num   = 5;
            m_words = {};
            for (int i = 0; i < m_num; i++) m_words.push_back(rand_word(2));
            m_base  = $urandom_range(RAM_N - m_num);
            m_loop  = r[0];
            ra = (r == 0) ? 2 : 9 + $urandom_range(4);
            run_trace(ra + 12, -1, -1, ra);
        end
    endtask

    task automatic test_back_to_back();
        m_num   = 4;
        m_words = {};
        for (int i = 0; i < m_num; i++) m_words.push_back(rand_word(2));
        m_base  = $urandom_range(RAM_N - m_num);
        m_loop  = 1'b0;
        run_trace(done_edge() + 4, -1, 2 + $urandom_range(8), -1);
        run_trace(done_edge() + 4, -1, -1, -1);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        base_addr = '0;
        num_words = '0;
        loop_en   = 1'b0;
        for (int i = 0; i < RAM_N; i++) ram[i] = $urandom;
        test_reset();
        test_basic();
        test_loop_stop();
        test_zero_words();
        test_random();
        test_long_frames();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
